buffer_mem_responder: RTL

Responder end of the active-low single-port buffer-memory interface (`cenb`/`wenb`/`addr`/`data`) that the matrix-mult core drives for its input, weight, partial-sum and output buffers. It holds one buffer's storage, serves core accesses with fixed one-cycle read latency, and gives a host-side load/unload port the remaining cycles through a valid/ready handshake. One instance sits behind each buffer port of the test wrapper.

---
 rtl/buffer_mem_responder.sv | 124 ++++++++++++
 1 files changed

// File: rtl/buffer_mem_responder.sv
`default_nettype none
// =============================================================================
// buffer_mem_responder : one buffer's storage; core port has priority with a
//   fixed 1-cycle read, host load/unload port uses idle cycles via valid/ready.
// Revision: 1.0
// =============================================================================
module buffer_mem_responder #(
  parameter int WIDTH = 8,
  parameter int LANES = 4,
  parameter int DEPTH = 256,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                         clk_i,
  input  logic                         rstn_i,
  input  logic                         mem_cenb_i,
  input  logic                         mem_wenb_i,
  input  logic [AW-1:0]                mem_addr_i,
  input  logic [LANES-1:0][WIDTH-1:0]  mem_data_i,
  output logic [LANES-1:0][WIDTH-1:0]  mem_data_o,
  input  logic                         host_req_valid_i,
  output logic                         host_req_ready_o,
  input  logic                         host_req_we_i,
  input  logic [AW-1:0]                host_req_addr_i,
  input  logic [LANES-1:0][WIDTH-1:0]  host_req_wdata_i,
  output logic                         host_rsp_valid_o,
  input  logic                         host_rsp_ready_i,
  output logic [LANES-1:0][WIDTH-1:0]  host_rsp_data_o,
  output logic [15:0]                  stall_cnt_o
);

  localparam logic [0:0]  ST_IDLE     = 1'b0;
  localparam logic [0:0]  ST_PEND     = 1'b1;
  localparam logic [AW:0] C_DEPTH     = (AW+1)'(DEPTH);
  localparam logic [15:0] C_STALL_MAX = 16'hFFFF;

  logic [LANES-1:0][WIDTH-1:0] r_mem [DEPTH];
  logic [LANES-1:0][WIDTH-1:0] r_core_rdata;
  logic [LANES-1:0][WIDTH-1:0] r_rsp_data;
  logic [0:0]                  r_state;
  logic [0:0]                  w_state_nxt;
  logic [15:0]                 r_stall_cnt;

  logic w_core_wr;
  logic w_core_rd;
  logic w_host_fire;
  logic w_host_wr;
  logic w_host_rd;
  logic w_core_in_range;
  logic w_host_in_range;
  logic [LANES-1:0][WIDTH-1:0] w_core_word;
  logic [LANES-1:0][WIDTH-1:0] w_host_word;

  assign w_core_wr   = ~mem_cenb_i & ~mem_wenb_i;
  assign w_core_rd   = ~mem_cenb_i &  mem_wenb_i;
  assign w_host_fire = host_req_valid_i & host_req_ready_o;
  assign w_host_wr   = w_host_fire &  host_req_we_i;
  assign w_host_rd   = w_host_fire & ~host_req_we_i;

  // Only meaningful when DEPTH is not a power of two.
  assign w_core_in_range = {1'b0, mem_addr_i}      < C_DEPTH;
  assign w_host_in_range = {1'b0, host_req_addr_i} < C_DEPTH;

  always_comb begin
    w_core_word = '0;
    if (w_core_in_range) w_core_word = r_mem[mem_addr_i];
  end

  always_comb begin
    w_host_word = '0;
    if (w_host_in_range) w_host_word = r_mem[host_req_addr_i];
  end

  // Host is only ready when the core is idle, so the two writes never collide.
  always_ff @(posedge clk_i) begin
    if (w_core_wr && w_core_in_range) begin
      r_mem[mem_addr_i] <= mem_data_i;
    end else if (w_host_wr && w_host_in_range) begin
      r_mem[host_req_addr_i] <= host_req_wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_core_rdata <= '0;
    end else if (w_core_rd) begin
      r_core_rdata <= w_core_word;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_host_rd) w_state_nxt = ST_PEND;
      ST_PEND: if (host_rsp_ready_i && !w_host_rd) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state    <= ST_IDLE;
      r_rsp_data <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_host_rd) r_rsp_data <= w_host_word;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_stall_cnt <= '0;
    end else if (host_req_valid_i && !mem_cenb_i && r_stall_cnt != C_STALL_MAX) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign host_rsp_valid_o = (r_state == ST_PEND);
  assign host_req_ready_o = mem_cenb_i & (~host_rsp_valid_o | host_rsp_ready_i);
  assign host_rsp_data_o  = r_rsp_data;
  assign mem_data_o       = r_core_rdata;
  assign stall_cnt_o      = r_stall_cnt;

endmodule
`default_nettype wire
